// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard and flow control for a 5-stage in-order pipeline.
//
// Owns the per-stage valid flags (ID/EX/MEM/WB) and produces combinational
// stage-register load enables. It handles three events, in this priority:
//   mem_stall : MEM data access is outstanding; the whole pipe freezes.
//   redirect  : a taken branch/jump in EX; PC loads the target and the
//               ID instruction is flushed.
//   load_use  : the ID instruction needs a load result still in EX; ID and
//               PC hold for one cycle and a bubble goes into EX.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_inst_valid            fetch presents an instruction
//   id_rs1/id_rs2, id_uses_* ID source registers and their use flags
//   ex_rd/ex_wen/ex_is_load  EX destination, write enable, load flag
//   ex_redirect              EX instruction is a taken branch/jump
//   mem_req/mem_ready        MEM data access request / completion
//   *_ena                    stage register load enables
//   pc_redirect              PC selects the EX branch target
//   id/ex/mem/wb_valid       stage valid flags (wb_valid = commit)
//   perf_*                   64-bit performance counters
//
// Build option: define PIPE_CTRL_PERF_EN to include the performance
// counters. Without it the perf_* outputs are tied to zero.

module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_inst_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wen,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_ena,
    output logic        if_id_ena,
    output logic        id_ex_ena,
    output logic        ex_mem_ena,
    output logic        mem_wb_ena,
    output logic        pc_redirect,
    output logic        id_valid,
    output logic        ex_valid,
    output logic        mem_valid,
    output logic        wb_valid,
    output logic [63:0] perf_cycles,
    output logic [63:0] perf_instret,
    output logic [63:0] perf_stall
);

    logic r_id_valid;
    logic r_ex_valid;
    logic r_mem_valid;
    logic r_wb_valid;

    logic w_mem_stall;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_redirect;

    logic w_id_valid_nxt;
    logic w_ex_valid_nxt;
    logic w_mem_valid_nxt;
    logic w_wb_valid_nxt;

    // Hazard detection
    assign w_mem_stall = r_mem_valid & mem_req & ~mem_ready;
    assign w_rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd);
    assign w_rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd);
    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use  = r_id_valid & r_ex_valid & ex_is_load & ex_wen &
                         (ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);
    // A stalled MEM stage freezes EX, so the branch must wait for the stall
    // to clear before it can steer the PC.
    assign w_redirect  = r_ex_valid & ex_redirect & ~w_mem_stall;

    // Stage enables: forced low while in reset so nothing loads garbage.
    always_comb begin
        pc_ena      = 1'b0;
        if_id_ena   = 1'b0;
        id_ex_ena   = 1'b0;
        ex_mem_ena  = 1'b0;
        mem_wb_ena  = 1'b0;
        pc_redirect = 1'b0;
        if (!rst) begin
            id_ex_ena   = ~w_mem_stall;
            ex_mem_ena  = ~w_mem_stall;
            mem_wb_ena  = ~w_mem_stall;
            // Redirect overrides load_use: the hazarded ID instruction is
            // flushed anyway, so fetch may proceed to the target.
            if_id_ena   = ~w_mem_stall & (~w_load_use | w_redirect);
            pc_ena      = ~w_mem_stall & ((~w_load_use & if_inst_valid) | w_redirect);
            pc_redirect = w_redirect;
        end
    end

    // Valid-flag next state, priority mem_stall > redirect > load_use.
    always_comb begin
        w_wb_valid_nxt  = r_mem_valid & ~w_mem_stall;
        w_mem_valid_nxt = r_ex_valid;
        w_ex_valid_nxt  = r_id_valid & ~w_load_use & ~w_redirect;
        w_id_valid_nxt  = if_inst_valid;
        if (w_mem_stall) begin
            w_mem_valid_nxt = r_mem_valid;
            w_ex_valid_nxt  = r_ex_valid;
            w_id_valid_nxt  = r_id_valid;
        end else if (w_redirect) begin
            w_id_valid_nxt  = 1'b0;
        end else if (w_load_use) begin
            w_id_valid_nxt  = r_id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid  <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            r_id_valid  <= w_id_valid_nxt;
            r_ex_valid  <= w_ex_valid_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_wb_valid  <= w_wb_valid_nxt;
        end
    end

    assign id_valid  = r_id_valid;
    assign ex_valid  = r_ex_valid;
    assign mem_valid = r_mem_valid;
    assign wb_valid  = r_wb_valid;

`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] r_perf_cycles;
    logic [63:0] r_perf_instret;
    logic [63:0] r_perf_stall;

    // Counters wrap naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles  <= 64'd0;
            r_perf_instret <= 64'd0;
            r_perf_stall   <= 64'd0;
        end else begin
            r_perf_cycles <= r_perf_cycles + 64'd1;
            if (r_wb_valid)
                r_perf_instret <= r_perf_instret + 64'd1;
            if (w_mem_stall | w_load_use)
                r_perf_stall <= r_perf_stall + 64'd1;
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_instret = r_perf_instret;
    assign perf_stall   = r_perf_stall;
`else
    assign perf_cycles  = 64'd0;
    assign perf_instret = 64'd0;
    assign perf_stall   = 64'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of per-cycle vectors walked in one
// continuous run after reset, followed by hand-written sequences for reset
// during a stall and for the performance counters.

module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        if_inst_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_uses_rs1, id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_wen, ex_is_load, ex_redirect;
    logic        mem_req, mem_ready;
    logic        pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena;
    logic        pc_redirect;
    logic        id_valid, ex_valid, mem_valid, wb_valid;
    logic [63:0] perf_cycles, perf_instret, perf_stall;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_inst_valid (if_inst_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_wen        (ex_wen),
        .ex_is_load    (ex_is_load),
        .ex_redirect   (ex_redirect),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_ena        (pc_ena),
        .if_id_ena     (if_id_ena),
        .id_ex_ena     (id_ex_ena),
        .ex_mem_ena    (ex_mem_ena),
        .mem_wb_ena    (mem_wb_ena),
        .pc_redirect   (pc_redirect),
        .id_valid      (id_valid),
        .ex_valid      (ex_valid),
        .mem_valid     (mem_valid),
        .wb_valid      (wb_valid),
        .perf_cycles   (perf_cycles),
        .perf_instret  (perf_instret),
        .perf_stall    (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ivld;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] exrd;
        logic       wen, ld, red, mreq, mrdy;
        logic [4:0] en;    // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic       pcr;
        logic [3:0] vld;   // {id, ex, mem, wb}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ivld, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic [4:0] exrd,
                                logic wen, logic ld, logic red,
                                logic mreq, logic mrdy,
                                logic [4:0] en, logic pcr, logic [3:0] vld);
        vec_t v;
        v.ivld = ivld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exrd = exrd; v.wen = wen; v.ld = ld; v.red = red;
        v.mreq = mreq; v.mrdy = mrdy; v.en = en; v.pcr = pcr; v.vld = vld;
        return v;
    endfunction

    // Default inputs: fetch valid, no hazard, no memory access.
    function automatic vec_t d(logic [4:0] en, logic pcr, logic [3:0] vld);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, en, pcr, vld);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        if_inst_valid = v.ivld;
        id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_rd = v.exrd; ex_wen = v.wen; ex_is_load = v.ld;
        ex_redirect = v.red; mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    task automatic defaults();
        apply(d(0, 0, 0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] en_now();
        return {pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena};
    endfunction

    function automatic logic [3:0] vld_now();
        return {id_valid, ex_valid, mem_valid, wb_valid};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int commits;

        // Pipeline fill after reset
        vecs.push_back(d(5'b11111, 0, 4'b0000));
        vecs.push_back(d(5'b11111, 0, 4'b1000));
        vecs.push_back(d(5'b11111, 0, 4'b1100));
        vecs.push_back(d(5'b11111, 0, 4'b1110));
        vecs.push_back(d(5'b11111, 0, 4'b1111));
        // Load-use on rs1, then the same fields against a bubble in EX
        vecs.push_back(mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 1, 5'b00111, 0, 4'b1111));
        vecs.push_back(mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 1, 5'b11111, 0, 4'b1011));
        vecs.push_back(d(5'b11111, 0, 4'b1101));
        // Load to x0: no hazard
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 5'b11111, 0, 4'b1110));
        // Load-use on rs2
        vecs.push_back(mk(1, 0, 7, 0, 1, 7, 1, 1, 0, 0, 1, 5'b00111, 0, 4'b1111));
        vecs.push_back(d(5'b11111, 0, 4'b1011));
        vecs.push_back(d(5'b11111, 0, 4'b1101));
        vecs.push_back(d(5'b11111, 0, 4'b1110));
        // Match on an unused source, and a load with ex_wen=0: no hazard
        vecs.push_back(mk(1, 7, 3, 0, 1, 7, 1, 1, 0, 0, 1, 5'b11111, 0, 4'b1111));
        vecs.push_back(mk(1, 7, 0, 1, 0, 7, 0, 1, 0, 0, 1, 5'b11111, 0, 4'b1111));
        // Redirect together with load-use: redirect wins
        vecs.push_back(mk(1, 5, 0, 1, 0, 5, 1, 1, 1, 0, 1, 5'b11111, 1, 4'b1111));
        vecs.push_back(d(5'b11111, 0, 4'b0011));
        vecs.push_back(d(5'b11111, 0, 4'b1001));
        vecs.push_back(d(5'b11111, 0, 4'b1100));
        vecs.push_back(d(5'b11111, 0, 4'b1110));
        // Four-cycle memory stall
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 4'b1111));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 4'b1110));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 4'b1110));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 0, 4'b1110));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 0, 4'b1110));
        vecs.push_back(d(5'b11111, 0, 4'b1111));
        // Redirect held off by a stall, then taken
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 0, 4'b1111));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 0, 4'b1110));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b11111, 1, 4'b1110));
        vecs.push_back(d(5'b11111, 0, 4'b0011));
        // Fetch gaps drain the pipe; mem_req without a MEM instruction is ignored
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b01111, 0, 4'b1001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b01111, 0, 4'b0100));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b01111, 0, 4'b0010));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b01111, 0, 4'b0001));
        vecs.push_back(d(5'b11111, 0, 4'b0000));

        // Reset held with fetch valid and a redirect request: all enables low
        rst = 1'b1;
        defaults();
        ex_redirect = 1'b1;
        repeat (3) begin
            tick();
            #3;
            chk("rst_en", en_now(), 5'b00000);
            chk("rst_pcr", pc_redirect, 1'b0);
        end
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #3;
            chk($sformatf("v%0d_en", i), en_now(), vecs[i].en);
            chk($sformatf("v%0d_pcr", i), pc_redirect, vecs[i].pcr);
            chk($sformatf("v%0d_vld", i), vld_now(), vecs[i].vld);
            tick();
        end

        // Reset asserted in the middle of a memory stall
        rst = 1'b1;
        defaults();
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        #3;
        chk("stall_en", en_now(), 5'b00000);
        chk("stall_vld", vld_now(), 4'b1111);
        tick();
        tick();
        rst = 1'b1;
        ex_redirect = 1'b1;
        #3;
        chk("rst_stall_en", en_now(), 5'b00000);
        chk("rst_stall_pcr", pc_redirect, 1'b0);
        tick();
        rst = 1'b0;
        ex_redirect = 1'b0;
        #3;
        chk("abandon_vld", vld_now(), 4'b0000);
        chk("abandon_en", en_now(), 5'b11111);
        tick();
        #3;
        chk("refill1_vld", vld_now(), 4'b1000);
        tick();
        #3;
        chk("refill2_vld", vld_now(), 4'b1100);

        // Ten instructions with one load-use hazard, then drain
        rst = 1'b1;
        defaults();
        tick();
        tick();
        rst = 1'b0;
        commits = 0;
        for (int c = 0; c < 21; c++) begin
            defaults();
            if_inst_valid = (c <= 10);
            if (c == 4) begin
                id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
                ex_rd = 5'd5; ex_wen = 1'b1; ex_is_load = 1'b1;
            end
            #3;
            if (wb_valid === 1'b1) commits++;
            tick();
        end
        defaults();
        #3;
        chk("commit_count", commits, 10);
        chk("drained_vld", vld_now(), 4'b0000);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles, 64'd21);
        chk("perf_instret", perf_instret, 64'd10);
        chk("perf_stall", perf_stall, 64'd1);
`else
        chk("perf_cycles_off", perf_cycles, 64'd0);
        chk("perf_instret_off", perf_instret, 64'd0);
        chk("perf_stall_off", perf_stall, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port if_inst_valid, input, 1 bit: fetch presents an instruction this cycle.
REQ-004 The block SHALL have the ports id_rs1 and id_rs2, input, 5 bits each: ID-stage source register indices.
REQ-005 The block SHALL have the ports id_uses_rs1 and id_uses_rs2, input, 1 bit each: the ID instruction reads that source.
REQ-006 The block SHALL have the ports ex_rd (input, 5 bits), ex_wen (input, 1 bit) and ex_is_load (input, 1 bit): destination, register write and load flag of the EX instruction.
REQ-007 The block SHALL have the port ex_redirect, input, 1 bit: the EX instruction is a taken branch or jump.
REQ-008 The block SHALL have the ports mem_req (input, 1 bit: MEM instruction accesses data memory) and mem_ready (input, 1 bit: data memory access completes this cycle).
REQ-009 The block SHALL have the outputs pc_ena, if_id_ena, id_ex_ena, ex_mem_ena and mem_wb_ena, 1 bit each: stage register load enables.
REQ-010 The block SHALL have the output pc_redirect, 1 bit: PC selects the EX branch target.
REQ-011 The block SHALL have the outputs id_valid, ex_valid, mem_valid and wb_valid, 1 bit each: per-stage valid flags; wb_valid=1 means commit this cycle.
REQ-012 The block SHALL have the outputs perf_cycles, perf_instret and perf_stall, 64 bits each: performance counters (see Configuration).

Function
REQ-013 mem_stall SHALL be mem_valid & mem_req & ~mem_ready.
REQ-014 load_use SHALL be id_valid & ex_valid & ex_is_load & ex_wen & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-015 redirect SHALL be ex_valid & ex_redirect & ~mem_stall; pc_redirect = redirect.
REQ-016 ex_mem_ena, id_ex_ena and mem_wb_ena SHALL each equal ~mem_stall; all stage enables are combinational, with no added latency.
REQ-017 if_id_ena SHALL be ~mem_stall & (~load_use | redirect).
REQ-018 pc_ena SHALL be ~mem_stall & ((~load_use & if_inst_valid) | redirect).
REQ-019 Valid flags SHALL update every clock as follows. wb_valid next = mem_valid & ~mem_stall. mem_valid next = mem_stall ? mem_valid : ex_valid.
REQ-020 ex_valid next SHALL be mem_stall ? ex_valid : (id_valid & ~load_use & ~redirect), so a load-use hazard inserts exactly one bubble.
REQ-021 id_valid next SHALL be: mem_stall -> hold; else redirect -> 0; else load_use -> hold; else if_inst_valid.
REQ-022 Priority SHALL be mem_stall > redirect > load_use when these occur in the same cycle; redirect flushes the ID instruction even if it has a load-use hazard.
REQ-023 A mem_stall SHALL last until mem_ready, with no timeout; an instruction SHALL commit exactly once (wb_valid=1 for one cycle per instruction).
REQ-024 ex_rd==0 SHALL never create a hazard.

Reset
REQ-025 While rst=1, all enables and pc_redirect SHALL be 0, and on the clock edge all valid flags and performance counters SHALL become 0.
REQ-026 A reset asserted during a mem_stall SHALL abandon the stalled instruction; after release, the pipeline refills from fetch.

Configuration
REQ-027 With macro PIPE_CTRL_PERF_EN defined, the counters SHALL count as follows, wrapping at 2^64. perf_cycles: +1 every non-reset cycle. perf_instret: +1 when wb_valid. perf_stall: +1 when mem_stall | load_use.
REQ-028 With PIPE_CTRL_PERF_EN undefined, the perf_* ports SHALL remain present, be constant 0, and no counter flops SHALL be synthesized.

Verification
REQ-029 Reset held 3 cycles, then release with if_inst_valid=1 continuously -> id/ex/mem/wb_valid rise on cycles 1/2/3/4 after release; all enables are 1.
REQ-030 EX holds a load with rd=5, ex_wen=1; ID reads rs1=5 -> if_id_ena=0, pc_ena=0, ex_valid=0 next cycle, and the ID instruction advances one cycle later.
REQ-031 mem_req=1 with mem_ready low for 4 cycles -> all enables are 0 for 4 cycles; wb_valid=0 during the stall, then exactly one wb_valid pulse after mem_ready.
REQ-032 ex_redirect=1 together with load_use=1 -> pc_redirect=1, pc_ena=1, id_valid=0 and ex_valid=0 next cycle.
REQ-033 ex_redirect=1 during mem_stall -> pc_redirect=0 until the stall clears, then redirect takes effect in the first non-stall cycle.
REQ-034 With PIPE_CTRL_PERF_EN, run 10 instructions with one load-use hazard -> perf_instret=10 and perf_stall=1; without the macro, all perf_* = 0.
